pc_call_sequencer: RTL and testbench

- Program-counter sequencer directly upstream of the 4-entry return-address stack.
- Turns NEXT/JUMP/CALL/RET requests into PC updates.
- Drives the stack's enable, read/write and data lines: push return address on CALL, pop it on RET.
- Tracks stack depth itself so CALL-on-full and RET-on-empty are caught before they reach the stack.

---
 rtl/pc_call_sequencer.sv | 156 +++++++++++++++
 tb/tb_pc_call_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_call_sequencer.sv
// Program-counter sequencer feeding a return-address stack: NEXT/JUMP/CALL/RET.
// Define PCSEQ_STACK_GUARD_EN to enable full/empty guarding and sticky error flags.
module pc_call_sequencer #(
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [1:0]              op,
  input  logic [AW-1:0]           target,
  input  logic [AW-1:0]           stk_pop_data,
  output logic                    stk_en,
  output logic                    stk_rw,
  output logic [AW-1:0]           stk_data,
  output logic [AW-1:0]           pc,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    busy,
  output logic                    overflow_err,
  output logic                    underflow_err
);

  localparam int DW = $clog2(DEPTH) + 1;

`ifdef PCSEQ_STACK_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP, S_POP_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_pc, w_pc_nxt;
  logic [AW-1:0]   r_target, w_target_nxt;
  logic [AW-1:0]   r_stk_data, w_stk_data_nxt;
  logic [DW-1:0]   r_depth, w_depth_nxt;
  logic            r_stk_en, w_stk_en_nxt;
  logic            r_stk_rw, w_stk_rw_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            r_udf, w_udf_nxt;

  logic            w_accept;
  logic            w_full;
  logic            w_empty;
  logic [AW-1:0]   w_pc_inc;

  assign w_accept = instr_valid && (r_state == S_IDLE);
  assign w_full   = (r_depth == DW'(DEPTH));
  assign w_empty  = (r_depth == '0);
  assign w_pc_inc = r_pc + AW'(1);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_target_nxt   = r_target;
    w_stk_data_nxt = r_stk_data;
    w_depth_nxt    = r_depth;
    w_stk_en_nxt   = 1'b0;
    w_stk_rw_nxt   = r_stk_rw;
    w_ovf_nxt      = r_ovf;
    w_udf_nxt      = r_udf;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op)
            OP_NEXT: w_pc_nxt = w_pc_inc;
            OP_JUMP: w_pc_nxt = target;
            OP_CALL: begin
              if (GUARD_EN && w_full) begin
                w_ovf_nxt = 1'b1;
                w_pc_nxt  = w_pc_inc;
              end else begin
                w_state_nxt    = S_PUSH;
                w_stk_en_nxt   = 1'b1;
                w_stk_rw_nxt   = 1'b0;
                w_stk_data_nxt = w_pc_inc;
                w_target_nxt   = target;
              end
            end
            OP_RET: begin
              if (GUARD_EN && w_empty) begin
                w_udf_nxt = 1'b1;
                w_pc_nxt  = w_pc_inc;
              end else begin
                w_state_nxt  = S_POP;
                w_stk_en_nxt = 1'b1;
                w_stk_rw_nxt = 1'b1;
              end
            end
          endcase
        end
      end
      S_PUSH: begin
        w_pc_nxt    = r_target;
        w_depth_nxt = w_full ? r_depth : r_depth + DW'(1);
        w_state_nxt = S_IDLE;
      end
      S_POP: begin
        // Pop data arrives the cycle after the strobe, so wait one cycle.
        w_state_nxt = S_POP_WAIT;
      end
      S_POP_WAIT: begin
        w_pc_nxt    = stk_pop_data;
        w_depth_nxt = w_empty ? r_depth : r_depth - DW'(1);
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_target   <= '0;
      r_stk_data <= '0;
      r_depth    <= '0;
      r_stk_en   <= 1'b0;
      r_stk_rw   <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_target   <= w_target_nxt;
      r_stk_data <= w_stk_data_nxt;
      r_depth    <= w_depth_nxt;
      r_stk_en   <= w_stk_en_nxt;
      r_stk_rw   <= w_stk_rw_nxt;
      r_ovf      <= w_ovf_nxt;
      r_udf      <= w_udf_nxt;
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign instr_ready   = !busy;
  assign pc            = r_pc;
  assign depth         = r_depth;
  assign stk_en        = r_stk_en;
  assign stk_rw        = r_stk_rw;
  assign stk_data      = r_stk_data;
  assign overflow_err  = GUARD_EN & r_ovf;
  assign underflow_err = GUARD_EN & r_udf;

endmodule

// File: tb/tb_pc_call_sequencer.sv
// Randomized self-checking bench for pc_call_sequencer with a transaction-level
// reference model and a behavioural 4-entry stack responder.
module tb_pc_call_sequencer;

  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] EMPTY_VAL = 4'hA;

`ifdef PCSEQ_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    op;
  logic [AW-1:0] target;
  logic [AW-1:0] stk_pop_data;
  logic          stk_en;
  logic          stk_rw;
  logic [AW-1:0] stk_data;
  logic [AW-1:0] pc;
  logic [2:0]    depth;
  logic          busy;
  logic          overflow_err;
  logic          underflow_err;

  pc_call_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .op            (op),
    .target        (target),
    .stk_pop_data  (stk_pop_data),
    .stk_en        (stk_en),
    .stk_rw        (stk_rw),
    .stk_data      (stk_data),
    .pc            (pc),
    .depth         (depth),
    .busy          (busy),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stack responder: drops pushes when full, returns EMPTY_VAL on empty pop.
  logic [AW-1:0] dev_mem [DEPTH];
  int            dev_sp;
  always @(posedge clk) begin
    if (rst) begin
      dev_sp       <= 0;
      stk_pop_data <= '0;
    end else if (stk_en) begin
      if (!stk_rw) begin
        if (dev_sp < DEPTH) begin
          dev_mem[dev_sp] <= stk_data;
          dev_sp          <= dev_sp + 1;
        end
      end else if (dev_sp > 0) begin
        stk_pop_data <= dev_mem[dev_sp-1];
        dev_sp       <= dev_sp - 1;
      end else begin
        stk_pop_data <= EMPTY_VAL;
      end
    end
  end

  // Cycle-level invariants on the stack strobe and handshake.
  bit   mon_on  = 1'b0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (mon_on) begin
      check("stk_en_back_to_back", stk_en && prev_en, 0);
      check("stk_en_while_idle", stk_en && !busy, 0);
      check("ready_is_not_busy", instr_ready, !busy);
    end
    prev_en <= stk_en;
  end

  // Reference model: architectural state plus a queue of return addresses.
  logic [AW-1:0] m_pc;
  int            m_depth;
  logic          m_ovf, m_udf;
  logic [AW-1:0] m_q [$];
  logic [AW-1:0] m_last_push;

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = '0; m_depth = 0; m_ovf = 1'b0; m_udf = 1'b0;
    m_q.delete();
    m_last_push = '0;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [AW-1:0] t);
    int wait_cyc = 0;
    int n_busy = 0, n_push = 0, n_pop = 0;
    int e_busy = 0, e_push = 0, e_pop = 0;
    logic [AW-1:0] push_val = '0;
    logic [AW-1:0] e_push_val = '0;

    while (!instr_ready && wait_cyc < 10) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("ready_before_request", instr_ready, 1);

    instr_valid = 1'b1; op = o; target = t;
    case (o)
      2'd0: m_pc = m_pc + 4'd1;
      2'd1: m_pc = t;
      2'd2: begin
        if (GUARD && m_depth == DEPTH) begin
          m_ovf = 1'b1;
          m_pc  = m_pc + 4'd1;
        end else begin
          e_busy = 1; e_push = 1;
          e_push_val  = m_pc + 4'd1;
          m_last_push = e_push_val;
          if (m_q.size() < DEPTH) m_q.push_back(e_push_val);
          m_pc = t;
          if (m_depth < DEPTH) m_depth++;
        end
      end
      default: begin
        if (GUARD && m_depth == 0) begin
          m_udf = 1'b1;
          m_pc  = m_pc + 4'd1;
        end else begin
          e_busy = 2; e_pop = 1;
          if (m_q.size() > 0) m_pc = m_q.pop_back();
          else m_pc = EMPTY_VAL;
          if (m_depth > 0) m_depth--;
        end
      end
    endcase

    @(posedge clk); #1;
    while (busy && n_busy < 8) begin
      n_busy++;
      if (stk_en && !stk_rw) begin n_push++; push_val = stk_data; end
      if (stk_en && stk_rw) n_pop++;
      // Requests while busy must be ignored, including a changing target.
      instr_valid = 1'($urandom_range(0, 1));
      op          = 2'($urandom);
      target      = AW'($urandom);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;

    check("busy_cycles", n_busy, e_busy);
    check("push_strobes", n_push, e_push);
    check("pop_strobes", n_pop, e_pop);
    check("push_data", push_val, e_push_val);
    check("stk_data_hold", stk_data, m_last_push);
    check("pc", pc, m_pc);
    check("depth", depth, m_depth);
    check("overflow_err", overflow_err, m_ovf);
    check("underflow_err", underflow_err, m_udf);
    check("stk_en_after_op", stk_en, 0);
    check("ready_after_op", instr_ready, 1);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; op = '0; target = '0;
    do_reset();
    mon_on = 1'b1;

    check("rst_pc", pc, 0);
    check("rst_depth", depth, 0);
    check("rst_stk_en", stk_en, 0);
    check("rst_stk_rw", stk_rw, 0);
    check("rst_stk_data", stk_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow_err, 0);
    check("rst_udf", underflow_err, 0);

    // 17 NEXTs: pc wraps 15 -> 0 and ends at 1.
    for (int i = 0; i < 17; i++) do_op(2'd0, '0);
    check("next_wrap_final", pc, 1);

    // CALL from pc=3 to 9, then RET back to 4.
    do_op(2'd1, 4'd3);
    do_op(2'd2, 4'd9);
    check("call_pc", pc, 9);
    do_op(2'd3, '0);
    check("ret_pc", pc, 4);

    // Four nested CALLs then a fifth at full depth.
    do_reset();
    for (int i = 1; i <= 4; i++) do_op(2'd2, AW'(i));
    do_op(2'd2, 4'd7);

    // RET at empty from pc=6.
    do_reset();
    do_op(2'd1, 4'd6);
    do_op(2'd3, '0);

    // Reset asserted while the RET sits in POP.
    do_reset();
    do_op(2'd1, 4'd5);
    do_op(2'd2, 4'd2);
    instr_valid = 1'b1; op = 2'd3; target = '0;
    @(posedge clk); #1;
    check("pop_state_stk_en", stk_en, 1);
    check("pop_state_stk_rw", stk_rw, 1);
    check("pop_state_busy", busy, 1);
    rst = 1'b1; op = 2'd1; target = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0; instr_valid = 1'b0;
    check("midpop_rst_pc", pc, 0);
    check("midpop_rst_depth", depth, 0);
    check("midpop_rst_stk_en", stk_en, 0);
    check("midpop_rst_busy", busy, 0);
    check("midpop_rst_ready", instr_ready, 1);
    m_pc = '0; m_depth = 0; m_ovf = 1'b0; m_udf = 1'b0;
    m_q.delete(); m_last_push = '0;

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else do_op(2'($urandom_range(0, 3)), AW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
